// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        BURST = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_1  = 2'b00,
        SZ_4  = 2'b01,
        SZ_8  = 2'b10,
        SZ_16 = 2'b11
    } size_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    function automatic logic [4:0] size_to_beats(input size_e sz);
        case (sz)
            SZ_1:    return 5'd1;
            SZ_4:    return 5'd4;
            SZ_8:    return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input chooser: round-robin on ties, or data port always wins when FIXED_PRIO is set.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_req_if,
    input  logic  i_req_d,
    input  logic  i_update,
    output port_e o_win
);

    port_e r_last;

    always_comb begin
        o_win = PORT_IF;
        if (i_req_if && i_req_d) begin
            if (FIXED_PRIO) begin
                o_win = PORT_D;
            end else begin
                o_win = (r_last == PORT_IF) ? PORT_D : PORT_IF;
            end
        end else if (i_req_d) begin
            o_win = PORT_D;
        end
    end

    // Reset to DATA so that the first tie goes to instruction fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= PORT_D;
        end else if (i_update && (i_req_if || i_req_d)) begin
            r_last <= o_win;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction-fetch bursts and data single-word accesses
// share one memory command port through an IDLE/ISSUE/WAIT/BURST sequencer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic [1:0]    if_size,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_enable,
    output logic          mem_read_write,
    output logic [1:0]    mem_access_size,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    input  logic          mem_busy
);

    state_e        r_state;
    state_e        w_next;
    port_e         r_port;
    port_e         w_win;
    logic [AW-1:0] r_addr;
    size_e         r_size;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [4:0]    r_cnt;
    logic [4:0]    w_beats;
    logic          w_arb_go;
    logic          w_last;

    assign w_arb_go = (r_state == IDLE) && !mem_busy && (if_req || d_req);
    assign w_beats  = size_to_beats(r_size);
    assign w_last   = (r_cnt == (w_beats - 5'd1));

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .i_update (w_arb_go),
        .o_win    (w_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_port  <= PORT_IF;
            r_addr  <= '0;
            r_size  <= SZ_1;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_arb_go) begin
                r_port <= w_win;
                if (w_win == PORT_D) begin
                    r_addr  <= d_addr;
                    r_size  <= SZ_1;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr  <= if_addr;
                    r_size  <= size_e'(if_size);
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (r_state == WAIT) begin
                r_cnt <= '0;
            end else if (r_state == BURST) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        if_gnt         = 1'b0;
        if_rvalid      = 1'b0;
        if_rdata       = '0;
        if_done        = 1'b0;
        d_gnt          = 1'b0;
        d_rvalid       = 1'b0;
        d_rdata        = '0;
        d_done         = 1'b0;
        mem_enable     = 1'b0;
        mem_read_write = 1'b0;
        mem_data_in    = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_go) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_enable     = 1'b1;
                mem_read_write = ~r_we;
                if (r_port == PORT_D) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
                // Only the data port can latch a write, so completion is immediate.
                if (r_we) begin
                    d_done      = 1'b1;
                    mem_data_in = r_wdata;
                    w_next      = IDLE;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_next = BURST;
            end
            BURST: begin
                if (r_port == PORT_D) begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_data_out;
                    d_done   = w_last;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_data_out;
                    if_done   = w_last;
                end
                if (w_last) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign mem_address     = r_addr;
    assign mem_access_size = r_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written tie, mid-burst reset and cross-port contention sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  if_size;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_data_out = '0;
    logic        mem_busy;

    logic        if_gnt, if_rvalid, if_done, d_gnt, d_rvalid, d_done;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_enable, mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_address, mem_data_in;

    logic        f_if_gnt, f_if_rvalid, f_if_done, f_d_gnt, f_d_rvalid, f_d_done;
    logic [31:0] f_if_rdata, f_d_rdata;
    logic        f_mem_enable, f_mem_read_write;
    logic [1:0]  f_mem_access_size;
    logic [31:0] f_mem_address, f_mem_data_in;

    mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_enable(mem_enable), .mem_read_write(mem_read_write),
        .mem_access_size(mem_access_size), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
        .if_gnt(f_if_gnt), .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata), .if_done(f_if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata), .d_done(f_d_done),
        .mem_enable(f_mem_enable), .mem_read_write(f_mem_read_write),
        .mem_access_size(f_mem_access_size), .mem_address(f_mem_address),
        .mem_data_in(f_mem_data_in), .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_en = 0;
    int n_gnt = 0;
    int last_if_done_cyc = -1;
    logic prev_en = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {16'hC0DE, 5'd0, a[10:0]};
    endfunction

    function automatic int tb_beats(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    // Memory responder: reads start one cycle after the command, one word per cycle.
    logic [31:0] wr_mem [int unsigned];
    logic [31:0] shadow [int unsigned];
    logic        m_wait = 1'b0;
    logic [4:0]  m_left = '0;
    logic [31:0] m_ptr = '0;

    assign mem_busy = m_wait || (m_left != 5'd0);

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_enable) begin
            if (mem_read_write) begin
                m_ptr  <= mem_address;
                m_left <= 5'(tb_beats(mem_access_size));
                m_wait <= 1'b1;
            end else begin
                wr_mem[mem_address] = mem_data_in;
            end
        end else if (m_wait || (m_left != 5'd0)) begin
            m_wait       <= 1'b0;
            mem_data_out <= wr_mem.exists(m_ptr) ? wr_mem[m_ptr] : init_word(m_ptr);
            m_ptr        <= m_ptr + 32'd1;
            m_left       <= m_left - 5'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk1("excl_gnt", if_gnt && d_gnt, 1'b0);
            chk1("excl_rvalid", if_rvalid && d_rvalid, 1'b0);
            chk1("excl_done", if_done && d_done, 1'b0);
            chk1("en_with_gnt", mem_enable, if_gnt || d_gnt);
            chk1("en_single_cycle", mem_enable && prev_en, 1'b0);
            chk1("en_while_busy", mem_enable && mem_busy, 1'b0);
            if (mem_enable) n_en++;
            if (if_gnt || d_gnt) n_gnt++;
            if (if_done) last_if_done_cyc = cyc;
        end
        prev_en = mem_enable;
    end

    typedef struct {
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_first;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic txn(input vec_t v, input bit chk_lat, output int gnt_cyc);
        int          waited;
        int          nb;
        logic        got;
        logic [31:0] exp;
        if (v.port_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr; if_size = v.size;
        end
        waited = 0;
        got = 1'b0;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            got = v.port_d ? d_gnt : if_gnt;
        end
        gnt_cyc = cyc;
        if (v.port_d) d_req = 1'b0; else if_req = 1'b0;
        chk1("gnt_seen", got, 1'b1);
        if (!got) return;
        if (chk_lat) chk("gnt_latency", 32'(waited), 32'd1);
        chk("cmd_addr", mem_address, v.addr);
        chk1("cmd_rw", mem_read_write, ~v.we);
        chk("cmd_size", {30'd0, mem_access_size}, v.port_d ? 32'd0 : {30'd0, v.size});
        if (v.port_d && v.we) begin
            chk1("wr_done", d_done, 1'b1);
            chk("wr_data", mem_data_in, v.wdata);
            shadow[v.addr] = v.wdata;
            @(negedge clk);
            chk1("wr_done_clear", d_done, 1'b0);
            return;
        end
        chk("rd_data_in_zero", mem_data_in, 32'd0);
        @(negedge clk);
        chk1("wait_no_rvalid", v.port_d ? d_rvalid : if_rvalid, 1'b0);
        nb = v.port_d ? 1 : tb_beats(v.size);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            exp = (k == 0) ? v.exp_first : sh_word(v.addr + 32'(k));
            chk1("beat_valid", v.port_d ? d_rvalid : if_rvalid, 1'b1);
            chk("beat_data", v.port_d ? d_rdata : if_rdata, exp);
            chk1("beat_done", v.port_d ? d_done : if_done, k == nb - 1);
            chk1("other_quiet", v.port_d ? (if_rvalid || if_done) : (d_rvalid || d_done), 1'b0);
        end
        @(negedge clk);
        chk1("post_quiet", v.port_d ? (d_rvalid || d_done) : (if_rvalid || if_done), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gc, gc_if, gc_d, nr, nf, viol, nbusy;
        logic got;
        logic ord_r [4];
        logic ord_f [4];
        vec_t v_post, v_if16, v_drd;

        vecs[0] = '{0, 0, 32'h100, 2'd1, 32'h0, 32'hC0DE0100};
        vecs[1] = '{1, 1, 32'h200, 2'd0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1, 0, 32'h200, 2'd0, 32'h0, 32'hDEADBEEF};
        vecs[3] = '{0, 0, 32'h300, 2'd0, 32'h0, 32'hC0DE0300};
        vecs[4] = '{1, 1, 32'h044, 2'd0, 32'h12345678, 32'h0};
        vecs[5] = '{0, 0, 32'h040, 2'd2, 32'h0, 32'hC0DE0040};
        vecs[6] = '{1, 0, 32'h044, 2'd0, 32'h0, 32'h12345678};
        vecs[7] = '{0, 0, 32'h200, 2'd3, 32'h0, 32'hDEADBEEF};
        vecs[8] = '{1, 0, 32'h7F0, 2'd0, 32'h0, 32'hC0DE07F0};
        v_post  = '{0, 0, 32'h100, 2'd1, 32'h0, 32'hC0DE0100};
        v_if16  = '{0, 0, 32'h000, 2'd3, 32'h0, 32'hC0DE0000};
        v_drd   = '{1, 0, 32'h044, 2'd0, 32'h0, 32'h12345678};

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; if_size = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {24'd0, if_gnt, if_rvalid, if_done, d_gnt, d_rvalid, d_done,
                          mem_enable, mem_read_write}, 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_size", {30'd0, mem_access_size}, 32'd0);
        chk("rst_wdata", mem_data_in, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            txn(vecs[i], 1'b1, gc);
        end

        // Ties from reset: round-robin alternates, fixed priority always picks data.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h500; if_size = 2'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        nr = 0; nf = 0;
        for (int i = 0; i < 60 && (nr < 4 || nf < 4); i++) begin
            @(negedge clk);
            if (nr < 4 && (if_gnt || d_gnt)) begin ord_r[nr] = d_gnt; nr++; end
            if (nf < 4 && (f_if_gnt || f_d_gnt)) begin ord_f[nf] = f_d_gnt; nf++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("tie_rr_count", 32'(nr), 32'd4);
        chk("tie_fp_count", 32'(nf), 32'd4);
        if (nr == 4) begin
            chk1("tie_rr_0", ord_r[0], 1'b0);
            chk1("tie_rr_1", ord_r[1], 1'b1);
            chk1("tie_rr_2", ord_r[2], 1'b0);
            chk1("tie_rr_3", ord_r[3], 1'b1);
        end
        if (nf == 4) begin
            chk1("tie_fp_0", ord_f[0], 1'b1);
            chk1("tie_fp_1", ord_f[1], 1'b1);
            chk1("tie_fp_2", ord_f[2], 1'b1);
            chk1("tie_fp_3", ord_f[3], 1'b1);
        end
        repeat (4) @(negedge clk);

        // Reset during the third beat of a 16-word burst.
        if_req = 1'b1; if_addr = 32'h400; if_size = 2'd3;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = if_gnt;
        end
        if_req = 1'b0;
        chk1("rst_burst_gnt", got, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk1("rst_beat3_valid", if_rvalid, 1'b1);
        chk("rst_beat3_data", if_rdata, 32'hC0DE0402);
        reset = 1'b1;
        #1;
        chk("rst_async_clear", {24'd0, if_gnt, if_rvalid, if_done, d_gnt, d_rvalid, d_done,
                                mem_enable, mem_read_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100; if_size = 2'd1;
        viol = 0; nbusy = 0;
        for (int i = 0; i < 40 && mem_busy; i++) begin
            nbusy++;
            if (if_rvalid || if_done || if_gnt || d_gnt || mem_enable) viol++;
            @(negedge clk);
        end
        chk("rst_quiet_while_busy", 32'(viol), 32'd0);
        chk1("rst_busy_held", nbusy > 5, 1'b1);
        chk1("rst_busy_fell", mem_busy, 1'b0);
        txn(v_post, 1'b1, gc);

        // Data request raised in the middle of a 16-word fetch burst.
        fork
            begin
                txn(v_if16, 1'b1, gc_if);
            end
            begin
                repeat (5) @(negedge clk);
                txn(v_drd, 1'b0, gc_d);
            end
        join
        chk1("d_after_if", gc_d > gc_if, 1'b1);
        chk("d_gnt_after_if_done", 32'(gc_d), 32'(last_if_done_cyc + 2));

        repeat (3) @(negedge clk);
        chk("en_vs_gnt", 32'(n_en), 32'(n_gnt));
        chk("en_total", 32'(n_en), 32'(NV + 8));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
